// File: rtl/sar_afe_responder_if.sv
// Switch/comparator interface between a SAR controller and the AFE responder.
interface sar_afe_responder_if #(
    parameter int unsigned N = 4
);
    localparam int unsigned CW = $clog2(N + 1);

    logic [7:1]    S;
    logic          S2b;
    logic          comp_clk;
    logic [N-1:0]  vin_code;
    logic          decision;
    logic [N-1:0]  result_code;
    logic          conv_done;
    logic          protocol_err;
    logic [CW-1:0] cmp_count;

    // Controller side: drives switches, strobe and emulated input.
    modport master (
        output S, S2b, comp_clk, vin_code,
        input  decision, result_code, conv_done, protocol_err, cmp_count
    );

    // Responder side: answers with the comparator decision and status.
    modport slave (
        input  S, S2b, comp_clk, vin_code,
        output decision, result_code, conv_done, protocol_err, cmp_count
    );
endinterface

// File: rtl/sar_afe_responder.sv
// Digital stand-in for the SAR switched-cap DAC and comparator: decodes the
// controller's switch patterns, runs the binary search on a held input code,
// reconstructs the result and flags any protocol violation.
module sar_afe_responder #(
    parameter int unsigned N = 4
) (
    input  logic               clk_1Mhz,
    input  logic               reset,
    sar_afe_responder_if.slave afe
);
    localparam int unsigned   CW        = $clog2(N + 1);
    localparam logic [N-1:0]  STEP_INIT = {1'b1, {(N - 1){1'b0}}};
    localparam logic [CW-1:0] CNT_FULL  = CW'(N);
    localparam logic [CW-1:0] LAST_BIT  = CW'(N - 1);

    typedef enum logic [2:0] {R_IDLE, R_SMP, R_CMP, R_APP, R_DEC} state_t;
    typedef enum logic [2:0] {P_ILL, P_RST, P_SMP, P_CMP, P_UP, P_DN, P_DEC} pat_t;

    state_t        r_state, w_state_nxt;
    pat_t          r_pat_q, w_pat;
    logic [N-1:0]  r_vin_held, w_vin_held_nxt;
    logic [N-1:0]  r_acc, w_acc_nxt;
    logic [N-1:0]  r_step, w_step_nxt;
    logic [CW-1:0] r_bit_idx, w_bit_idx_nxt;
    logic [CW-1:0] r_cmp_count, w_cmp_count_nxt;
    logic [N-1:0]  r_result_code, w_result_nxt;
    logic          r_conv_done, w_conv_done_nxt;
    logic          r_protocol_err, w_err_nxt;
    logic          r_comp_q;
    logic          w_comp_rise;
    logic          w_hold;
    logic          w_decision;

    // Switch pattern decode; anything unlisted is illegal.
    always_comb begin
        w_pat = P_ILL;
        case ({afe.S, afe.S2b})
            8'b1110_1101: w_pat = P_RST;
            8'b0011_0000: w_pat = P_SMP;
            8'b0100_1010: w_pat = P_CMP;
            8'b0100_0100: w_pat = P_UP;
            8'b0100_0001: w_pat = P_DN;
            8'b0010_1000: w_pat = P_DEC;
            default:      w_pat = P_ILL;
        endcase
    end

    assign w_comp_rise = afe.comp_clk & ~r_comp_q;
    assign w_hold      = (w_pat == r_pat_q) && (w_pat != P_ILL);

    // Comparator; a zero step means no trial bit is pending, so it reads 0.
    assign w_decision = (r_step != '0) &&
                        ({1'b0, r_vin_held} >= ({1'b0, r_acc} + {1'b0, r_step}));

    // Next-state and datapath updates for the search protocol.
    always_comb begin
        w_state_nxt     = r_state;
        w_vin_held_nxt  = r_vin_held;
        w_acc_nxt       = r_acc;
        w_step_nxt      = r_step;
        w_bit_idx_nxt   = r_bit_idx;
        w_cmp_count_nxt = r_cmp_count;
        w_result_nxt    = r_result_code;
        w_conv_done_nxt = 1'b0;
        w_err_nxt       = r_protocol_err;

        if (w_comp_rise) begin
            if (r_cmp_count != CNT_FULL) begin
                w_cmp_count_nxt = r_cmp_count + CW'(1);
            end
            if ((r_state != R_CMP) && (w_pat != P_CMP)) begin
                w_err_nxt = 1'b1;
            end
        end

        if (w_pat == P_SMP) begin
            // Sampling restarts the conversion from any state.
            if (r_state != R_SMP) begin
                w_vin_held_nxt  = afe.vin_code;
                w_acc_nxt       = '0;
                w_step_nxt      = STEP_INIT;
                w_bit_idx_nxt   = '0;
                w_cmp_count_nxt = '0;
                w_state_nxt     = R_SMP;
            end
        end else if (!w_hold) begin
            case (r_state)
                R_IDLE: begin
                    if (w_pat != P_RST) begin
                        w_err_nxt = 1'b1;
                    end
                end
                R_SMP, R_DEC: begin
                    if (w_pat == P_CMP) begin
                        w_state_nxt = R_CMP;
                    end else begin
                        w_err_nxt   = 1'b1;
                        w_state_nxt = R_IDLE;
                    end
                end
                R_CMP: begin
                    if (w_pat == P_UP) begin
                        if (!w_decision) w_err_nxt = 1'b1;
                        w_acc_nxt   = r_acc + r_step;
                        w_state_nxt = R_APP;
                    end else if (w_pat == P_DN) begin
                        if (w_decision) w_err_nxt = 1'b1;
                        w_state_nxt = R_APP;
                    end else begin
                        w_err_nxt   = 1'b1;
                        w_state_nxt = R_IDLE;
                    end
                end
                R_APP: begin
                    if (w_pat == P_DEC) begin
                        w_step_nxt    = r_step >> 1;
                        w_bit_idx_nxt = r_bit_idx + CW'(1);
                        if (r_bit_idx == LAST_BIT) begin
                            w_result_nxt    = r_acc;
                            w_conv_done_nxt = 1'b1;
                            w_state_nxt     = R_IDLE;
                            if (r_cmp_count != CNT_FULL) w_err_nxt = 1'b1;
                        end else begin
                            w_state_nxt = R_DEC;
                        end
                    end else begin
                        w_err_nxt   = 1'b1;
                        w_state_nxt = R_IDLE;
                    end
                end
                default: begin
                    w_err_nxt   = 1'b1;
                    w_state_nxt = R_IDLE;
                end
            endcase
        end
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk_1Mhz) begin
        if (!reset) begin
            r_state        <= R_IDLE;
            r_pat_q        <= P_ILL;
            r_vin_held     <= '0;
            r_acc          <= '0;
            r_step         <= '0;
            r_bit_idx      <= '0;
            r_cmp_count    <= '0;
            r_result_code  <= '0;
            r_conv_done    <= 1'b0;
            r_protocol_err <= 1'b0;
            r_comp_q       <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_pat_q        <= w_pat;
            r_vin_held     <= w_vin_held_nxt;
            r_acc          <= w_acc_nxt;
            r_step         <= w_step_nxt;
            r_bit_idx      <= w_bit_idx_nxt;
            r_cmp_count    <= w_cmp_count_nxt;
            r_result_code  <= w_result_nxt;
            r_conv_done    <= w_conv_done_nxt;
            r_protocol_err <= w_err_nxt;
            r_comp_q       <= afe.comp_clk;
        end
    end

    assign afe.decision     = w_decision;
    assign afe.result_code  = r_result_code;
    assign afe.conv_done    = r_conv_done;
    assign afe.protocol_err = r_protocol_err;
    assign afe.cmp_count    = r_cmp_count;
endmodule

// File: tb/tb_sar_afe_responder.sv
// Directed bench for sar_afe_responder acting as a SAR controller.
`timescale 1ns/1ps
module tb_sar_afe_responder;
    localparam int unsigned N = 4;

    localparam logic [7:0] PAT_RST = 8'b1110_1101;
    localparam logic [7:0] PAT_SMP = 8'b0011_0000;
    localparam logic [7:0] PAT_CMP = 8'b0100_1010;
    localparam logic [7:0] PAT_UP  = 8'b0100_0100;
    localparam logic [7:0] PAT_DN  = 8'b0100_0001;
    localparam logic [7:0] PAT_DEC = 8'b0010_1000;
    localparam logic [7:0] PAT_ILL = 8'b1111_1110;

    logic clk_1Mhz = 1'b0;
    logic reset    = 1'b0;

    sar_afe_responder_if #(.N(N)) afe ();

    sar_afe_responder #(.N(N)) dut (
        .clk_1Mhz (clk_1Mhz),
        .reset    (reset),
        .afe      (afe)
    );

    always #500 clk_1Mhz = ~clk_1Mhz;

    // Expected outputs after the most recent clock edge.
    logic         e_done    = 1'b0;
    logic         e_err     = 1'b0;
    logic         e_dec_chk = 1'b0;
    logic         e_dec     = 1'b0;
    int           e_result  = 0;
    int           e_cnt     = 0;
    logic         comp_prev = 1'b0;
    logic [N-1:0] dec_log   = '0;
    int           n_chk     = 0;
    int           n_fail    = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Binary search answers bit k (MSB first) of the input code.
    function automatic logic exp_bit(input int v, input int k);
        return 1'(v >> (N - 1 - k));
    endfunction

    // Per-cycle comparison of the DUT against the expected outputs.
    always @(negedge clk_1Mhz) begin
        check("conv_done", 32'(afe.conv_done), 32'(e_done));
        check("protocol_err", 32'(afe.protocol_err), 32'(e_err));
        check("result_code", 32'(afe.result_code), 32'(e_result));
        check("cmp_count", 32'(afe.cmp_count), 32'(e_cnt));
        if (e_dec_chk) check("decision", 32'(afe.decision), 32'(e_dec));
    end

    // One clock: drive pattern and strobe, track strobe count, wait past compare.
    task automatic cyc(input logic [7:0] pat, input logic comp);
        afe.S        = pat[7:1];
        afe.S2b      = pat[0];
        afe.comp_clk = comp;
        if (pat == PAT_SMP) e_cnt = 0;
        else if (comp && !comp_prev && e_cnt < N) e_cnt++;
        comp_prev = comp;
        @(posedge clk_1Mhz);
        @(negedge clk_1Mhz);
        #1;
        e_done = 1'b0;
    endtask

    task automatic do_reset();
        reset     = 1'b0;
        e_done    = 1'b0;
        e_err     = 1'b0;
        e_result  = 0;
        e_cnt     = 0;
        e_dec_chk = 1'b1;
        e_dec     = 1'b0;
        cyc(PAT_RST, 1'b0);
        reset = 1'b1;
    endtask

    // One search bit: compare (with optional strobe), apply, decide.
    task automatic bit_step(input int vin, input int k, input bit pulse);
        logic b;
        b = exp_bit(vin, k);
        e_dec_chk = 1'b1;
        e_dec     = b;
        cyc(PAT_CMP, pulse);
        dec_log = {dec_log[N-2:0], afe.decision};
        cyc(PAT_CMP, 1'b0);
        e_dec_chk = 1'b0;
        cyc(b ? PAT_UP : PAT_DN, 1'b0);
        if (k == int'(N) - 1) begin
            e_done   = 1'b1;
            e_result = vin;
            if (e_cnt != int'(N)) e_err = 1'b1;
        end else begin
            e_dec_chk = 1'b1;
            e_dec     = exp_bit(vin, k + 1);
        end
        cyc(PAT_DEC, 1'b0);
    endtask

    task automatic conversion(input int vin, input int skip_bit, input int nbits);
        afe.vin_code = N'(vin);
        e_dec_chk    = 1'b1;
        e_dec        = exp_bit(vin, 0);
        cyc(PAT_SMP, 1'b0);
        for (int k = 0; k < nbits; k++) bit_step(vin, k, k != skip_bit);
    endtask

    initial begin
        afe.S        = PAT_RST[7:1];
        afe.S2b      = PAT_RST[0];
        afe.comp_clk = 1'b0;
        afe.vin_code = '0;

        do_reset();
        check("lit_reset_result", 32'(afe.result_code), 32'd0);

        // Nominal conversion of 11.
        conversion(11, -1, N);
        check("lit_dec_seq_11", 32'(dec_log), 32'b1011);
        check("lit_result_11", 32'(afe.result_code), 32'd11);
        check("lit_cnt_11", 32'(afe.cmp_count), 32'd4);

        // Back-to-back extremes, SMP issued while conv_done is high.
        conversion(0, -1, N);
        check("lit_dec_seq_0", 32'(dec_log), 32'b0000);
        conversion(15, -1, N);
        check("lit_dec_seq_15", 32'(dec_log), 32'b1111);
        check("lit_result_15", 32'(afe.result_code), 32'd15);
        cyc(PAT_RST, 1'b0);
        cyc(PAT_RST, 1'b0);

        // UP against a 0 decision: sticky error survives a later good conversion.
        do_reset();
        afe.vin_code = '0;
        cyc(PAT_SMP, 1'b0);
        cyc(PAT_CMP, 1'b1);
        e_dec_chk = 1'b0;
        e_err     = 1'b1;
        cyc(PAT_UP, 1'b0);
        cyc(PAT_RST, 1'b0);
        conversion(5, -1, N);
        check("lit_err_sticky", 32'(afe.protocol_err), 32'd1);
        check("lit_result_5", 32'(afe.result_code), 32'd5);

        // Comparator strobe outside a compare phase.
        do_reset();
        e_err = 1'b1;
        cyc(PAT_RST, 1'b1);
        cyc(PAT_RST, 1'b0);
        check("lit_stray_cnt", 32'(afe.cmp_count), 32'd1);

        // Illegal pattern mid-conversion: error, back to idle, no done pulse.
        do_reset();
        afe.vin_code = 4'd9;
        e_dec = 1'b1;
        cyc(PAT_SMP, 1'b0);
        cyc(PAT_CMP, 1'b1);
        e_dec_chk = 1'b0;
        cyc(PAT_UP, 1'b0);
        e_err = 1'b1;
        cyc(PAT_ILL, 1'b0);
        cyc(PAT_RST, 1'b0);
        check("lit_ill_err", 32'(afe.protocol_err), 32'd1);

        // Reset after the second DEC abandons the conversion silently.
        do_reset();
        conversion(9, -1, 2);
        do_reset();
        conversion(6, -1, N);
        check("lit_result_6", 32'(afe.result_code), 32'd6);
        check("lit_err_6", 32'(afe.protocol_err), 32'd0);

        // Missing strobe on one bit: short count flagged, result still lands.
        conversion(13, 2, N);
        check("lit_cnt_short", 32'(afe.cmp_count), 32'd3);
        check("lit_err_short", 32'(afe.protocol_err), 32'd1);
        check("lit_result_13", 32'(afe.result_code), 32'd13);

        cyc(PAT_RST, 1'b0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/sar_afe_responder.md
Name: sar_afe_responder

Overview:
- Synthesizable digital stand-in for the SAR ADC analog front end: switched-cap DAC plus comparator.
- Sits on the far side of the SAR controller's switch interface (S[7:1], S2b, comp_clk).
- Decodes switch patterns, holds a sampled digital input code and performs the binary-search comparison.
- Drives `decision` back to the controller.
- Used for FPGA bring-up and closed-loop verification of the SAR control FSM; also reports its own reconstructed code and protocol violations.

Parameters:
N, 4, conversion resolution in bits (decisions per conversion)

Ports:
clk_1Mhz  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-low
S  input  7 (S[7:1])  switch controls from SAR controller
S2b  input  1  complementary DAC switch
comp_clk  input  1  comparator strobe; sampled on clk_1Mhz, never used as a clock
vin_code  input  N  emulated analog input, captured at sampling
decision  output  1  comparator result
result_code  output  N  code reconstructed by responder at end of conversion
conv_done  output  1  one-cycle pulse when result_code updates
protocol_err  output  1  sticky violation flag
cmp_count  output  clog2(N+1)  comp_clk rising edges seen in current conversion

Behaviour:
- Interface: reset is synchronous, active-low; clock is clk_1Mhz.
- Reset (reset==0 at a clk edge) clears all state. Output values after reset:
  - decision=0, result_code=0, conv_done=0, protocol_err=0, cmp_count=0.
  - Internal: vin_held=0, acc=0, step=0, bit_idx=0, comp_q=0, state=R_IDLE.
  - Reset mid-conversion abandons the conversion with no conv_done.
- Pattern decode is combinational from {S[7:1],S2b}; all other values decode as ILL:
  - RST: S2,S3,S5,S6,S7=1, S2b=1, S1,S4=0
  - SMP: S4,S5=1, all else 0
  - CMP: S1,S3,S6=1, all else 0
  - UP: S2,S6=1, all else 0
  - DN: S6=1, S2b=1, all else 0
  - DEC: S3,S5=1, all else 0
- decision = (vin_held >= acc + step), computed in N+1 bits, combinational from registers only. It is valid one cycle after SMP/DEC is registered, before the controller samples it.
- FSM states and transitions, evaluated each edge on the current pattern. Holding the same pattern is legal (no-op).
  - R_IDLE:
    - RST: stay.
    - SMP: vin_held<=vin_code, acc<=0, step<=2^(N-1), bit_idx<=0, cmp_count<=0 -> R_SMP.
  - R_SMP / R_DEC:
    - CMP -> R_CMP.
  - R_CMP:
    - UP: requires decision==1, else set protocol_err. acc<=acc+step -> R_APP.
    - DN: requires decision==0, else set protocol_err. acc unchanged -> R_APP.
  - R_APP:
    - DEC: step<=step>>1, bit_idx<=bit_idx+1.
    - If bit_idx==N-1: result_code<=acc, conv_done<=1 for one cycle -> R_IDLE.
    - Otherwise -> R_DEC.
    - If cmp_count != N at this point, set protocol_err.
- Any other pattern in any state, including ILL, sets protocol_err and returns to R_IDLE.
  - Exceptions: RST in R_IDLE is legal; SMP from any state is legal and restarts the conversion.
- comp_clk handling:
  - comp_q registers comp_clk.
  - A rising edge (comp_clk & ~comp_q) increments cmp_count, saturating at N.
  - A rising edge seen while state is not R_CMP and pattern is not CMP sets protocol_err.
- Search order is MSB first. With vin_code < 2^N, result_code == vin_held after N steps.
  - vin_code all ones: every decision is 1, result = 2^N-1, no overflow because N+1-bit compare is used.
  - vin_code = 0: every decision is 0, result 0.
- Simultaneous events: a reset edge overrides all else. A SMP arriving in the same cycle as conv_done still pulses conv_done; the new conversion starts on the next SMP-registered cycle.
- protocol_err clears only on reset.

Test Plan:
- N=4, vin_code=4'b1011, closed loop with the SAR controller -> decisions 1,0,1,1 in order; result_code=11; conv_done one cycle after the 4th DEC; protocol_err=0; cmp_count=4.
- vin_code=0 then vin_code=15 on back-to-back conversions -> decisions all 0 / all 1; result_code 0 then 15; no err.
- Driven pattern UP while decision==0 (vin=0, first CMP) -> protocol_err=1 next cycle and stays 1 until reset.
- Inject ILL pattern 7'b1111111 / S2b=0 mid-conversion -> protocol_err=1, state R_IDLE, no conv_done.
- Assert reset (0) after 2nd DEC of conversion with vin=9, then run a full conversion with vin=6 -> no conv_done for the aborted one; result_code=6; err=0.
- Suppress comp_clk pulses for one bit -> cmp_count=3 at end, protocol_err=1, result_code still updated.
